uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter: the transmit counterpart of the team's uart_rx.
//  - Accepts bytes on a StreamBus-style valid/ready slave port.
//  - Serialises each byte onto the idle-high line `tx`: 8N1 by default, LSB first.
//  - Shares the uartPkg::state encoding (WAIT, START, DATA, STOP) with the receiver.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency in Hz
//  BAUD       115200      line rate; DIV = CLK_HZ/BAUD (integer floor)
//  N          8           data bits per frame
//  STOP_BITS  1           number of stop bits, 1 or 2
// PORTS
//  clk    in   1   system clock; all logic is on the rising edge
//  rst    in   1   synchronous, active-high reset
//  data   in   N   byte to send; sampled only on the handshake
//  valid  in   1   data is valid
//  ready  out  1   block can accept a byte this cycle
//  tx     out  1   serial line, idle high
//  busy   out  1   a frame is in progress (state != WAIT)
// BEHAVIOUR
//  Elaboration: DIV < 2, N < 1, or STOP_BITS not in {1,2} -> $error.
//  All outputs are registered. Values during and right after reset:
//   - tx = 1, busy = 0, ready = 0, state = WAIT, counters = 0.
//   - ready rises in the first cycle after rst deasserts.
//  Handshake:
//   - A transfer occurs in any cycle where valid && ready.
//   - data is latched into a shift register; ready drops on the next edge.
//   - valid while ready = 0 is ignored; data need not be held.
//  States (uartPkg::state):
//   - WAIT: tx = 1, ready = 1. On transfer -> START.
//   - START: tx = 0 for DIV cycles -> DATA.
//   - DATA: tx = shreg[0] for DIV cycles per bit, then shift right.
//     After N bits -> STOP. The bit counter wraps to 0.
//   - STOP: tx = 1 for STOP_BITS*DIV cycles -> WAIT; ready = 1 again.
//  Timing:
//   - Latency: handshake in cycle t -> tx falls at edge t+1.
//   - Frame length is exactly (1+N+STOP_BITS)*DIV cycles.
//   - Baud counter counts 0..DIV-1 and restarts at every state entry.
//     Width = $clog2(DIV). No drift between bits.
//  Back-to-back:
//   - Re-acceptance happens in the WAIT cycle after STOP.
//   - Successive start edges are therefore (1+N+STOP_BITS)*DIV + 1 cycles apart.
//  Boundaries:
//   - rst mid-frame: tx returns to 1 at the next edge and the frame is abandoned.
//     No partial resend.
//   - rst asserted together with valid: no transfer.
//   - busy = 1 from START entry through the last STOP cycle.
// TESTING (CLK_HZ=16, BAUD=1 -> DIV=16, N=8, STOP_BITS=1)
//  1. Reset held 5 cycles, then released -> tx=1, busy=0 throughout; ready=1 on first cycle after release.
//  2. Send 0xA5 -> tx holds 0,1,0,1,0,0,1,0,1,1 for 16 cycles each.
//     Frame lasts 160 cycles; ready is back at cycle 161.
//  3. valid held high with 0x00 then 0xFF -> second start edge 161 cycles after the first; no byte lost.
//  4. Pulse valid with 0x3C while busy -> ignored; line matches the single in-flight frame only.
//  5. rst pulsed in DATA bit 3 -> tx=1 next cycle, busy=0.
//     A new 0x81 is then sent correctly.
//  6. STOP_BITS=2: send 0x55 -> stop high for 32 cycles; frame = 176 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-stream port of the UART transmitter.
// Handshake: a byte moves in any cycle where valid && ready are both high at
// the rising clock edge; the master may change or drop data/valid freely
// while ready is low, and nothing is consumed in that case.
interface uart_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: takes bytes from a valid/ready stream port and
// serialises each one LSB first onto the idle-high line tx as
// start bit, N data bits, STOP_BITS stop bits. Every output is a register.
// The state encoding (WAIT, START, DATA, STOP) matches the receiver and is
// visible on the state output.
module uart_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int N         = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   s,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int BW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(N - 1);
  localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);

  // Reject parameter sets that cannot form a valid frame.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (N < 1) begin : g_bad_n
    $error("uart_tx: N must be at least 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;     // cycles spent in the current bit, restarts on every bit
  logic [BW-1:0] bitcnt;  // data bits sent in DATA, stop bits sent in STOP
  logic [N-1:0]  shreg;   // bit 0 is the data bit currently on the line
  logic [N-1:0]  shnext;
  logic          ready_q;

  assign s.ready = ready_q;
  assign state   = st;

  // Next shift-register contents once the current data bit has been sent.
  always_comb begin
    shnext = shreg >> 1;
  end

  // Frame sequencer: one state per frame segment, outputs set on the edge
  // that enters each segment so the line changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= WAIT;
      cnt     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (st)
        WAIT: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          ready_q <= 1'b1;
          cnt     <= '0;
          bitcnt  <= '0;
          // ready_q is low only in the first cycle after reset, so a byte
          // offered then is not taken.
          if (s.valid && ready_q) begin
            shreg   <= s.data;
            st      <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_MAX) begin
            cnt    <= '0;
            bitcnt <= '0;
            st     <= DATA;
            tx     <= shreg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bitcnt == BIT_MAX) begin
              bitcnt <= '0;
              st     <= STOP;
              tx     <= 1'b1;
            end else begin
              bitcnt <= bitcnt + BW'(1);
              shreg  <= shnext;
              tx     <= shnext[0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bitcnt == STOP_MAX) begin
              bitcnt  <= '0;
              st      <= WAIT;
              busy    <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st      <= WAIT;
          tx      <= 1'b1;
          busy    <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits, DIV = 16) driven
// by directed byte sequences. A line-level model turns each accepted byte
// into the list of tx values it must produce, one per clock, and a compare
// process checks tx/busy/ready/state of both instances every cycle.
module tb_uart_tx;

  localparam int DIV = 16;

  logic       clk;
  logic       rst;
  logic [7:0] data_v [2];
  logic [1:0] valid_v;
  logic [1:0] ready_v;
  logic [1:0] tx_v;
  logic [1:0] busy_v;
  logic [1:0] state_a;
  logic [1:0] state_b;

  int cyc;
  int n_tests;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  uart_tx_if #(.N(8)) bus_a ();
  uart_tx_if #(.N(8)) bus_b ();

  assign bus_a.data  = data_v[0];
  assign bus_a.valid = valid_v[0];
  assign ready_v[0]  = bus_a.ready;
  assign bus_b.data  = data_v[1];
  assign bus_b.valid = valid_v[1];
  assign ready_v[1]  = bus_b.ready;

  uart_tx #(.CLK_HZ(16), .BAUD(1), .N(8), .STOP_BITS(1)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .s     (bus_a.slave),
    .tx    (tx_v[0]),
    .busy  (busy_v[0]),
    .state (state_a)
  );

  uart_tx #(.CLK_HZ(16), .BAUD(1), .N(8), .STOP_BITS(2)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .s     (bus_b.slave),
    .tx    (tx_v[1]),
    .busy  (busy_v[1]),
    .state (state_b)
  );

  // ---------------- scoreboard / model ----------------
  // exp_q[d] holds the tx value still owed for every remaining frame cycle.
  logic [0:0] exp_q [2][$];
  logic [1:0] m_tx;
  logic [1:0] m_busy;
  logic [1:0] m_ready;
  logic [1:0] m_state [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: advances one clock per rising edge using the inputs seen at it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      int sb;
      int flen;
      int pos;
      int seg;
      sb   = (d == 0) ? 1 : 2;
      flen = (1 + 8 + sb) * DIV;
      if (rst) begin
        exp_q[d].delete();
        m_tx[d]    = 1'b1;
        m_busy[d]  = 1'b0;
        m_ready[d] = 1'b0;
        m_state[d] = 2'd0;
      end else if (exp_q[d].size() == 0 && !(m_ready[d] && valid_v[d])) begin
        m_tx[d]    = 1'b1;
        m_busy[d]  = 1'b0;
        m_ready[d] = 1'b1;
        m_state[d] = 2'd0;
      end else begin
        if (exp_q[d].size() == 0) begin
          for (int sl = 0; sl < 1 + 8 + sb; sl++) begin
            logic b;
            b = (sl == 0) ? 1'b0 : (sl <= 8) ? data_v[d][sl-1] : 1'b1;
            for (int k = 0; k < DIV; k++) exp_q[d].push_back(b);
          end
        end
        m_tx[d]    = exp_q[d].pop_front();
        m_busy[d]  = 1'b1;
        m_ready[d] = 1'b0;
        pos = flen - 1 - exp_q[d].size();
        seg = pos / DIV;
        m_state[d] = (seg == 0) ? 2'd1 : (seg <= 8) ? 2'd2 : 2'd3;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx_a", tx_v[0], m_tx[0]);
      chk("busy_a", busy_v[0], m_busy[0]);
      chk("ready_a", ready_v[0], m_ready[0]);
      chk("state_a", state_a, m_state[0]);
      chk("tx_b", tx_v[1], m_tx[1]);
      chk("busy_b", busy_v[1], m_busy[1]);
      chk("ready_b", ready_v[1], m_ready[1]);
      chk("state_b", state_b, m_state[1]);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge. Offers byte b to instance d and returns at the
  // falling edge right after the accepting rising edge (frame cycle 1).
  task automatic send(input int d, input logic [7:0] b, input bit keep, output int hs_cyc);
    int n;
    data_v[d]  = b;
    valid_v[d] = 1'b1;
    n = 0;
    while (!ready_v[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[d]) begin
      chk("send_timeout", 32'd0, 32'd1);
      valid_v[d] = 1'b0;
      hs_cyc = cyc;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
    if (!keep) valid_v[d] = 1'b0;
  endtask

  // Walks a whole frame from frame cycle 1, checking the mid-bit line value
  // against a hand-written bit pattern and the end-of-frame ready/busy edge.
  task automatic walk_frame(input int d, input logic [10:0] lit, input int flen);
    for (int j = 0; j <= flen; j++) begin
      if (j % DIV == 8 && j < flen) chk("lit_bit", tx_v[d], lit[j/DIV]);
      if (j == flen - 1) begin
        chk("lit_last_busy", busy_v[d], 1'b1);
        chk("lit_last_ready", ready_v[d], 1'b0);
      end
      if (j == flen) begin
        chk("lit_end_busy", busy_v[d], 1'b0);
        chk("lit_end_ready", ready_v[d], 1'b1);
      end
      if (j < flen) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h1;
    int h2;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    rst        = 1'b1;
    valid_v    = 2'b00;
    data_v[0]  = 8'h00;
    data_v[1]  = 8'h00;

    // 1. Reset held 5 cycles; valid offered alongside rst must not transfer.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", tx_v, 2'b11);
      chk("rst_busy", busy_v, 2'b00);
      chk("rst_ready", ready_v, 2'b00);
      if (i >= 2) begin
        valid_v[0] = 1'b1;
        data_v[0]  = 8'hEE;
      end
    end
    rst        = 1'b0;
    valid_v[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready_v, 2'b11);
    chk("busy_after_rst", busy_v, 2'b00);
    chk("tx_after_rst", tx_v, 2'b11);

    // 2. 0xA5 -> line 0,1,0,1,0,0,1,0,1,1.
    send(0, 8'hA5, 1'b0, h1);
    walk_frame(0, 11'b11101001010, 160);

    // 3. valid held: 0x00 then 0xFF back to back.
    send(0, 8'h00, 1'b1, h1);
    data_v[0] = 8'hFF;
    send(0, 8'hFF, 1'b0, h2);
    chk("b2b_gap", h2 - h1, 161);
    walk_frame(0, 11'b11111111110, 160);

    // 4. valid pulsed with 0x3C in the middle of a 0xC3 frame.
    send(0, 8'hC3, 1'b0, h1);
    repeat (50) @(negedge clk);
    data_v[0]  = 8'h3C;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (109) @(negedge clk);
    chk("ign_ready", ready_v[0], 1'b1);
    chk("ign_busy", busy_v[0], 1'b0);
    repeat (3) @(negedge clk);
    chk("ign_no_frame_busy", busy_v[0], 1'b0);
    chk("ign_no_frame_tx", tx_v[0], 1'b1);

    // 5. Reset in DATA bit 3, then a clean 0x81 frame.
    send(0, 8'h12, 1'b0, h1);
    repeat (70) @(negedge clk);
    chk("pre_rst_state", state_a, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx_v[0], 1'b1);
    chk("midrst_busy", busy_v[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h81, 1'b0, h1);
    walk_frame(0, 11'b11100000010, 160);

    // 6. Two stop bits: 0x55, 176-cycle frame.
    send(1, 8'h55, 1'b0, h1);
    walk_frame(1, 11'b11010101010, 176);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the run must end by itself.
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
